// File: rtl/latch_wr_sched.sv
// ============================================================================
// Module   : latch_wr_sched
// Purpose  : Arbitrated write scheduler for a transparent-latch bank;
//            sequences setup / enable-open / hold around each latch enable.
// Option   : LATCH_WR_SCHED_RR_EN selects round-robin arbitration
//            (default: fixed priority, lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int NLAT      = 6,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_wdata,
  input  logic [NREQ*AW-1:0] i_waddr,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic               o_busy,
  output logic [NLAT-1:0]    o_latch_en,
  output logic [DW-1:0]      o_latch_d
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_OPEN  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] OPEN_LD  = 4'(OPEN_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  logic [2:0]      state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [IW-1:0]   winner, winner_nxt, win_sel;
  logic [AW-1:0]   addr, addr_nxt;
  logic            grant, found;
  int              idx;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic            busy_nxt;
  logic [NLAT-1:0] en_nxt;
  logic [DW-1:0]   d_nxt;
`ifdef LATCH_WR_SCHED_RR_EN
  logic [IW-1:0]   ptr, ptr_nxt;
`endif

  // Arbiter: first requester found scanning upward from the start index.
  always_comb begin
    win_sel = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_WR_SCHED_RR_EN
      idx = (int'(ptr) + i) % NREQ;
`else
      idx = i;
`endif
      if (!found && i_req[idx]) begin
        found   = 1'b1;
        win_sel = IW'(idx);
      end
    end
  end

  assign grant = (state == ST_IDLE) && (|i_req);

`ifdef LATCH_WR_SCHED_RR_EN
  assign ptr_nxt = IW'((int'(win_sel) + 1) % NREQ);
`endif

  // State register (also holds the registered outputs)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      winner     <= '0;
      addr       <= '0;
      o_gnt      <= '0;
      o_done     <= '0;
      o_busy     <= 1'b0;
      o_latch_en <= '0;
      o_latch_d  <= '0;
`ifdef LATCH_WR_SCHED_RR_EN
      ptr        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      winner     <= winner_nxt;
      addr       <= addr_nxt;
      o_gnt      <= gnt_nxt;
      o_done     <= done_nxt;
      o_busy     <= busy_nxt;
      o_latch_en <= en_nxt;
      o_latch_d  <= d_nxt;
`ifdef LATCH_WR_SCHED_RR_EN
      if (grant) ptr <= ptr_nxt;
`endif
    end
  end

  // Next-state: each phase loads its length-1 and exits when the count hits 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_OPEN;
          cnt_nxt   = OPEN_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_OPEN: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    winner_nxt = grant ? win_sel : winner;
    addr_nxt   = grant ? i_waddr[int'(win_sel)*AW +: AW] : addr;
    d_nxt      = grant ? i_wdata[int'(win_sel)*DW +: DW] : o_latch_d;
    busy_nxt   = (state_nxt != ST_IDLE);
    gnt_nxt    = (state_nxt != ST_IDLE) ? (NREQ'(1) << winner_nxt) : '0;
    done_nxt   = (state_nxt == ST_DONE) ? (NREQ'(1) << winner) : '0;
    en_nxt     = ((state_nxt == ST_OPEN) && (int'(addr) < NLAT)) ?
                 (NLAT'(1) << addr) : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_wr_sched.sv
// ============================================================================
// Module   : tb_latch_wr_sched
// Purpose  : Self-checking bench for latch_wr_sched against a cycle-offset
//            transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_wr_sched;

  localparam int NREQ = 4, DW = 8, NLAT = 6, AW = 3;
  localparam int S = 1, O = 2, H = 1;
  localparam int L = S + O + H + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ-1:0]    gnt, done;
  logic               busy;
  logic [NLAT-1:0]    latch_en;
  logic [DW-1:0]      latch_d;

  always #5 clk = ~clk;

  latch_wr_sched #(
    .NREQ(NREQ), .DW(DW), .NLAT(NLAT), .AW(AW),
    .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wdata(wdata),
    .i_waddr(waddr), .o_gnt(gnt), .o_done(done), .o_busy(busy),
    .o_latch_en(latch_en), .o_latch_d(latch_d)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a transaction is "active" for L-1 cycles after its grant edge;
  // k counts cycles since that edge.
  bit          active;
  int          k, win, wa, ptr;
  logic [DW-1:0] exp_d;
  int          done_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_WR_SCHED_RR_EN
      if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
`else
      if (r[i]) return i;
`endif
    end
    return 0;
  endfunction

  task automatic model_reset();
    active = 0; k = 0; win = 0; wa = 0; ptr = 0; exp_d = '0;
  endtask

  task automatic model_edge();
    if (active) begin
      k++;
      if (k == L) active = 0;
    end else if (|req) begin
      win    = pick(req);
      active = 1;
      k      = 1;
      wa     = int'(waddr[win*AW +: AW]);
      exp_d  = wdata[win*DW +: DW];
      ptr    = (win + 1) % NREQ;
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] e_gnt, e_done;
    logic [NLAT-1:0] e_en;
    e_gnt  = active ? NREQ'(1 << win) : '0;
    e_done = (active && k == L - 1) ? NREQ'(1 << win) : '0;
    e_en   = (active && k >= S + 1 && k <= S + O && wa < NLAT) ? NLAT'(1 << wa) : '0;
    chk("gnt",  32'(gnt),  32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(active));
    chk("en",   32'(latch_en), 32'(e_en));
    chk("d",    32'(latch_d),  32'(exp_d));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    for (int i = 0; i < NREQ; i++) if (done[i]) done_log.push_back(i);
  endtask

  task automatic set_req(input int r, input logic [DW-1:0] d, input int a);
    wdata[r*DW +: DW] = d;
    waddr[r*AW +: AW] = AW'(a);
    req[r] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; wdata = '0; waddr = '0;
    model_reset();
    #1;
    check_all();
    #7 rst_n = 1'b1;

    // Single write to latch 3
    set_req(0, 8'hA5, 3);
    repeat (L + 1) begin tick(); req &= ~done; end

    // Invalid latch address: enable must stay low
    set_req(2, 8'h3C, 7);
    repeat (L + 1) begin tick(); req &= ~done; end

    // Contention, each requester drops on its own done
    done_log.delete();
    req = '0;
    set_req(0, 8'h11, 0); set_req(1, 8'h22, 1); set_req(3, 8'h44, 5);
    repeat (3 * L + 2) begin tick(); req &= ~done; end
    chk("order_len", 32'(done_log.size()), 32'd3);
    if (done_log.size() == 3) begin
      chk("order0", 32'(done_log[0]), 32'd0);
      chk("order1", 32'(done_log[1]), 32'd1);
      chk("order2", 32'(done_log[2]), 32'd3);
    end

    // Request dropped during OPEN still completes
    set_req(1, 8'h5A, 2);
    tick(); tick();
    req = '0;
    repeat (L) tick();

    // Asynchronous reset during OPEN, request left pending
    set_req(3, 8'hC3, 4);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    repeat (L + 1) begin tick(); req &= ~done; end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (done[r]) req[r] = 1'b0;
        else if (!req[r] && ($urandom % 4 == 0))
          set_req(r, DW'($urandom), int'($urandom_range(0, 7)));
        else if (req[r] && ($urandom % 32 == 0)) req[r] = 1'b0;
        if ($urandom % 8 == 0) begin
          wdata[r*DW +: DW] = DW'($urandom);
          waddr[r*AW +: AW] = AW'($urandom_range(0, 7));
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
